// File: rtl/somador_1bit.sv
// somador_1bit: 1-bit full adder leaf cell with optional output register
// and an internal carry flop for LSB-first bit-serial addition.
module somador_1bit #(
  parameter bit REG_OUT   = 1'b1,
  parameter bit SERIAL_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic use_carry,
  output logic s,
  output logic cout,
  output logic out_valid,
  output logic carry_q
);

  logic ci;
  logic s_c;
  logic cout_c;

  assign ci     = (SERIAL_EN && use_carry) ? carry_q : cin;
  assign s_c    = a ^ b ^ ci;
  assign cout_c = (a & b) | (a & ci) | (b & ci);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (in_valid) begin
      carry_q <= cout_c;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic s_q;
      logic cout_q;
      logic ov_q;

      // s/cout keep their last result while idle; only out_valid drops
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s_q    <= 1'b0;
          cout_q <= 1'b0;
          ov_q   <= 1'b0;
        end else begin
          ov_q <= in_valid;
          if (in_valid) begin
            s_q    <= s_c;
            cout_q <= cout_c;
          end
        end
      end

      assign s         = s_q;
      assign cout      = cout_q;
      assign out_valid = ov_q;
    end else begin : g_comb
      assign s         = s_c;
      assign cout      = cout_c;
      assign out_valid = in_valid & rst_n;
    end
  endgenerate

endmodule

// File: tb/tb_somador_1bit.sv
// tb_somador_1bit: vector table plus scoreboard for the registered,
// combinational and non-serial variants of somador_1bit.
module tb_somador_1bit;

  logic clk = 1'b0;
  logic rst_n, in_valid, a, b, cin, use_carry;

  logic s, cout, ov, cq;
  logic s_c, cout_c, ov_c, cq_c;
  logic s_n, cout_n, ov_n, cq_n;

  always #5 clk = ~clk;

  somador_1bit #(.REG_OUT(1'b1), .SERIAL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .use_carry(use_carry),
    .s(s), .cout(cout), .out_valid(ov), .carry_q(cq)
  );

  somador_1bit #(.REG_OUT(1'b0), .SERIAL_EN(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .use_carry(use_carry),
    .s(s_c), .cout(cout_c), .out_valid(ov_c), .carry_q(cq_c)
  );

  somador_1bit #(.REG_OUT(1'b1), .SERIAL_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .use_carry(use_carry),
    .s(s_n), .cout(cout_n), .out_valid(ov_n), .carry_q(cq_n)
  );

  typedef struct packed {
    logic s;
    logic c;
  } res_t;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
    logic es;
    logic ec;
  } vec_t;

  res_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic mc;
  logic mn;
  logic ns_exp_s, ns_exp_c;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // called right after a falling edge; returns at the next falling edge
  task automatic step(input logic v, input logic ai, input logic bi,
                      input logic ci, input logic uc);
    logic [1:0] sm;
    logic [1:0] sn;
    logic       pushed;
    logic       ns_acc;
    res_t       r;
    in_valid  = v;
    a         = ai;
    b         = bi;
    cin       = ci;
    use_carry = uc;
    pushed    = 1'b0;
    ns_acc    = 1'b0;
    if (!rst_n) begin
      mc = 1'b0;
      mn = 1'b0;
    end else if (v) begin
      sm = {1'b0, ai} + {1'b0, bi} + {1'b0, (uc ? mc : ci)};
      sn = {1'b0, ai} + {1'b0, bi} + {1'b0, ci};
      q.push_back(res_t'{s: sm[0], c: sm[1]});
      pushed   = 1'b1;
      ns_acc   = 1'b1;
      ns_exp_s = sn[0];
      ns_exp_c = sn[1];
    end
    #1;
    chk("comb_ov", ov_c, v & rst_n);
    if (pushed) begin
      chk("comb_s", s_c, sm[0]);
      chk("comb_cout", cout_c, sm[1]);
    end
    if (pushed) mc = sm[1];
    if (ns_acc) mn = sn[1];
    @(posedge clk);
    @(negedge clk);
    chk("ov", ov, pushed);
    if (ov === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_empty", 1'b1, 1'b0);
      end else begin
        r = q.pop_front();
        chk("sb_s", s, r.s);
        chk("sb_cout", cout, r.c);
      end
    end
    chk("carry_q", cq, mc);
    chk("carry_q_comb", cq_c, mc);
    chk("carry_q_ns", cq_n, mn);
    if (ns_acc) begin
      chk("ns_s", s_n, ns_exp_s);
      chk("ns_cout", cout_n, ns_exp_c);
    end
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0; use_carry = 1'b0;
    mc = 1'b0;
    mn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ov", ov, 1'b0);
    chk("rst_s", s, 1'b0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_cq", cq, 1'b0);
    chk("rst_ov_comb", ov_c, 1'b0);
    chk("rst_cq_ns", cq_n, 1'b0);
    rst_n = 1'b1;

    // exhaustive, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
      chk($sformatf("tbl%0d_s", i), s, tbl[i].es);
      chk($sformatf("tbl%0d_cout", i), cout, tbl[i].ec);
    end

    // serial 0xB + 0x6 = 0x11
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ser0_s", s, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ser1_s", s, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ser2_s", s, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ser3_s", s, 1'b0);
    chk("ser_carry", cq, 1'b1);

    // hold with X inputs while idle
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'bx, 1'bx, 1'bx, 1'bx);
      chk("hold_s", s, 1'b0);
      chk("hold_cout", cout, 1'b1);
      chk("hold_ov", ov, 1'b0);
      chk("hold_cq", cq, 1'b1);
    end

    // reset mid-serial drops the beat and clears carry
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("midrst_ov", ov, 1'b0);
    chk("midrst_s", s, 1'b0);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_cq", cq, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("postrst_s", s, 1'b0);
    chk("postrst_cout", cout, 1'b0);
    chk("postrst_ns_s", s_n, 1'b1);

    // combinational variant: same-cycle result, then drop valid
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // non-serial variant ignores use_carry
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("noser_s", s_n, 1'b0);
    chk("noser_cout", cout_n, 1'b0);
    chk("ser_s", s, 1'b1);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/somador_1bit.md
Name:
somador_1bit

Overview:
- 1-bit full adder (sum and carry-out of a, b, cin), wrapped with an optional output register and an internal carry flop.
- Used standalone as the arithmetic leaf cell, or as a bit-serial adder: LSB first, carry fed back internally between beats.
- Single clock domain.

Parameters:
- REG_OUT, 1, 1 = s/cout/out_valid registered (latency 1 cycle); 0 = combinational outputs (latency 0).
- SERIAL_EN, 1, 1 = use_carry input honoured; 0 = use_carry ignored, carry always taken from cin.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  qualifies a, b, cin, use_carry for this cycle.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  external carry-in.
- use_carry  input  1  1 = use internal carry_q instead of cin (serial continuation beat).
- s  output  1  sum bit.
- cout  output  1  carry-out bit.
- out_valid  output  1  s/cout are valid.
- carry_q  output  1  stored carry from the last accepted beat.

Behaviour:
- Effective carry: ci = (SERIAL_EN and use_carry) ? carry_q : cin.
- Core, exact truth table over (a,b,ci):
  - s = a xor b xor ci.
  - cout = (a and b) or (a and ci) or (b and ci).
  - 000→s0 c0; 001→1 0; 010→1 0; 011→0 1; 100→1 0; 101→0 1; 110→0 1; 111→1 1.
- carry_q:
  - On a rising edge with rst_n=1 and in_valid=1, carry_q <= core cout.
  - Otherwise carry_q holds.
- REG_OUT=1:
  - On an accepted beat (in_valid=1), s/cout are registered from the core on that edge; out_valid=1 for exactly the following cycle.
  - With in_valid=0: out_valid <= 0; s/cout hold their last values.
  - Back-to-back valid beats produce back-to-back results, one per cycle, in order.
- REG_OUT=0:
  - s/cout driven directly by the core.
  - out_valid = in_valid and rst_n.
  - When in_valid=0, s/cout still reflect the current inputs; consumers must qualify with out_valid.
- Reset, rising edge with rst_n=0:
  - carry_q=0, out_valid=0.
  - With REG_OUT=1, also s=0 and cout=0.
  - Reset overrides a simultaneous in_valid; the beat is dropped.
  - Reset mid serial sequence clears carry_q; the next use_carry=1 beat uses carry 0.
- X tolerance: inputs sampled only while in_valid=1. X on a/b/cin/use_carry with in_valid=0 must not change state or registered outputs.
- Width rules: all signals 1 bit. No overflow detection; the overflow of a serial sum is the final carry_q / cout.
- Implementation: plain synthesizable logic, no latches, no initial blocks for function.

Test Plan:
- Exhaustive (REG_OUT=1): apply all 8 {a,b,cin} vectors 000..111 with in_valid=1, use_carry=0 → next cycle s/cout = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1, out_valid=1 each cycle; 8 tests, 0 errors.
- Serial 4-bit add (REG_OUT=1): 0xB+0x6, LSB first, beat0 cin=0 use_carry=0, beats1-3 use_carry=1 → s sequence 1,0,0,0, final carry_q=1 (result 0x11).
- Hold: one beat a=1,b=1,cin=0, then in_valid=0 with a=b=cin=X for 3 cycles → s=0, cout=1 held, out_valid=0 from the 2nd cycle, carry_q=1 unchanged.
- Reset mid-operation: carry_q=1, assert rst_n=0 for one edge together with in_valid=1, then beat a=0,b=0,use_carry=1 → s=0, cout=0, out_valid=0 during reset.
- Combinational (REG_OUT=0): a=1,b=0,cin=1,in_valid=1 → same cycle s=0, cout=1, out_valid=1; drop in_valid → out_valid=0.
- SERIAL_EN=0: carry_q=1, beat a=0,b=0,cin=0,use_carry=1 → s=0, cout=0 (use_carry ignored).
